enemy_fire_arbiter: RTL and testbench
=====================================

Name: enemy_fire_arbiter

Overview:
Shares a small pool of enemy projectile slots (ball instances) between several enemy requesters, e.g. enemy_run and turret enemies. Grants at most one launch per frame, using round-robin priority across requesters and a per-requester cooldown. Sequences each slot through a launch/flight/free lifecycle. Sits between the enemy modules' fire requests and the ball instances' fire/direction inputs, clocked on frame_clk.

Parameters:
N_REQ, 4, number of enemy requesters
N_SLOT, 2, number of shared projectile slots
COOLDOWN, 120, frames a requester is blocked after being granted (max 255)
LIFETIME, 200, frames after which an in-flight slot is force-freed (max 255)

Ports:
frame_clk  input  1  frame clock, one edge per video frame
Reset  input  1  asynchronous, active-high reset
play  input  1  game running; when low, all state holds
flush  input  1  synchronous clear of slots and cooldowns (game over / egg)
req  input  N_REQ  fire request level per enemy; high while alive, on screen and wanting to fire
req_dir  input  N_REQ  requested shot direction per enemy (1 = right)
slot_done  input  N_SLOT  projectile left the screen or hit the player; level, sampled per frame
grant  output  N_REQ  one-hot pulse, one frame wide, marking the requester served
slot_fire  output  N_SLOT  one-frame launch pulse to the ball instance
slot_dir  output  N_SLOT  latched direction for the slot
slot_busy  output  N_SLOT  slot is in LAUNCH or FLIGHT
slot_owner  output  N_SLOT*clog2(N_REQ)  index of the requester owning each slot

Behaviour:
- One clock (frame_clk); reset is asynchronous and active-high (Reset). All outputs are registered.
- Reset values:
  - grant, slot_fire, slot_busy, slot_dir, slot_owner = 0.
  - All slots IDLE.
  - All cooldown counters = 0.
  - Lifetime counters = 0.
  - Round-robin pointer rr = 0.
- Precedence per edge: Reset > flush > play=0 (hold; grant and slot_fire forced to 0) > normal operation.
- flush: at the edge, all slots go to IDLE, all cooldowns to 0, rr to 0, and all pulses to 0.
- Slot FSM, per slot:
  - IDLE -> LAUNCH on grant to this slot. Owner and dir are latched from the granted requester, the lifetime counter is loaded to 0, and slot_fire=1 for this frame.
  - LAUNCH -> FLIGHT unconditionally next edge; slot_fire returns to 0. slot_done is ignored in LAUNCH.
  - FLIGHT -> IDLE when slot_done=1, or when the lifetime counter reaches LIFETIME-1. Otherwise the counter increments.
  - slot_busy = (state != IDLE).
- Eligibility: requester i is eligible iff req[i]=1 and cooldown[i]=0.
- Grant selection, evaluated every play frame:
  - Target slot = lowest-index IDLE slot as of the current state.
  - If no slot is IDLE or no requester is eligible, there is no grant.
  - Otherwise grant the first eligible requester scanning rr, rr+1, … modulo N_REQ.
- On a grant to requester g:
  - grant[g]=1 for one frame.
  - cooldown[g] loaded to COOLDOWN.
  - rr set to (g+1) mod N_REQ.
- Cooldown: each play frame, every non-zero cooldown that was not just loaded decrements by 1, saturating at 0.
- Latency: a req rising before edge k with a free slot produces grant and slot_fire visible after edge k, in the same frame.
- A slot freed by slot_done at edge k is IDLE after k and can be granted at edge k+1. There is no same-edge reuse.
- A requester may own two slots simultaneously if its cooldown expires while its first shot is still in flight.
- Dropping req while cooldown is running does not clear the cooldown.
- With req held continuously, a sole requester fires every COOLDOWN+1 frames while slots allow.

Decomposition:
- Package enemy_pkg holds:
  - slot_state_t enum (IDLE, LAUNCH, FLIGHT).
  - Default constants ENEMY_COOLDOWN=120 and ENEMY_BULLET_LIFETIME=200.
  - Width constant OWNER_W.
- Sub-module enemy_fire_slot: one slot FSM with lifetime counter, instantiated N_SLOT times. The arbiter top holds rr, the cooldowns and the selection logic.

Test Plan:
- Reset with req=4'b1111 and play=1 -> first edge: grant=0001, slot_fire=01, slot_owner[0]=0. Next edge: grant=0010, slot_fire=10, owner[1]=1. Third edge: grant=0 (no free slot).
- Single req[2]=1 held, slot_done pulsed 5 frames after each launch -> grants at frames 0, 121, 242 (period COOLDOWN+1). cooldown[2] reads 0 exactly at the regrant frame.
- Both slots FLIGHT, slot_done=01 at edge k, req[3]=1 eligible -> slot 0 IDLE after k; grant=1000 and slot_fire=01 at edge k+1, not at k.
- Slot launched, slot_done held 0 -> slot_busy drops exactly LIFETIME+1=201 edges after launch (1 LAUNCH + 200 FLIGHT).
- Mid-flight with cooldowns non-zero, play=0 for 50 frames -> all counters, states and busy unchanged; grant and slot_fire stay 0. Resume continues from the held values.
- flush=1 for one edge while both slots are busy and rr=2 -> slot_busy=00, all cooldowns 0, rr=0. With req=1111 next frame, grant=0001. Asserting Reset mid-FLIGHT clears everything asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/enemy_pkg.sv
// rtl/enemy_pkg.sv - shared types and constants for the enemy fire arbiter
// Contents: slot_state_t slot lifecycle states, default cooldown/lifetime
// constants, default requester count and the owner index width helper.
package enemy_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        FLIGHT = 2'd2
    } slot_state_t;

    localparam int ENEMY_COOLDOWN        = 120;
    localparam int ENEMY_BULLET_LIFETIME = 200;
    localparam int ENEMY_N_REQ           = 4;
    localparam int OWNER_W               = $clog2(ENEMY_N_REQ);

    // Owner index width; a single requester still needs a 1-bit field.
    function automatic int owner_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/enemy_fire_slot.sv
// rtl/enemy_fire_slot.sv - one projectile slot: IDLE/LAUNCH/FLIGHT lifecycle
// Ports: frame_clk, Reset (async, active-high), play, flush,
//        launch/launch_owner/launch_dir (grant into this slot),
//        slot_done (projectile finished), fire (one-frame launch pulse),
//        dir/owner (latched at launch), busy (state != IDLE).
module enemy_fire_slot
    import enemy_pkg::*;
#(
    parameter int LIFETIME = ENEMY_BULLET_LIFETIME,
    parameter int OW       = OWNER_W
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          play,
    input  logic          flush,
    input  logic          launch,
    input  logic [OW-1:0] launch_owner,
    input  logic          launch_dir,
    input  logic          slot_done,
    output logic          fire,
    output logic          dir,
    output logic          busy,
    output logic [OW-1:0] owner
);

    slot_state_t   state, state_next;
    logic [7:0]    life, life_next;
    logic          fire_next, dir_next;
    logic [OW-1:0] owner_next;

    always_comb begin
        state_next = state;
        life_next  = life;
        fire_next  = 1'b0;
        dir_next   = dir;
        owner_next = owner;
        if (flush) begin
            state_next = IDLE;
            life_next  = '0;
        end else if (play) begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state_next = LAUNCH;
                        life_next  = '0;
                        fire_next  = 1'b1;
                        dir_next   = launch_dir;
                        owner_next = launch_owner;
                    end
                end
                // slot_done is deliberately ignored here: the ball has not
                // been released yet, so any done level belongs to a prior shot.
                LAUNCH: state_next = FLIGHT;
                FLIGHT: begin
                    if (slot_done || life == 8'(LIFETIME - 1)) begin
                        state_next = IDLE;
                        life_next  = '0;
                    end else begin
                        life_next = life + 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            life  <= '0;
            fire  <= 1'b0;
            dir   <= 1'b0;
            owner <= '0;
        end else begin
            state <= state_next;
            life  <= life_next;
            fire  <= fire_next;
            dir   <= dir_next;
            owner <= owner_next;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: rtl/enemy_fire_arbiter.sv
// rtl/enemy_fire_arbiter.sv - round-robin launch arbiter over shared projectile slots
// Ports: frame_clk, Reset (async, active-high), play, flush,
//        req/req_dir (per requester), slot_done (per slot),
//        grant (one-hot pulse), slot_fire, slot_dir, slot_busy,
//        slot_owner (packed OW bits per slot, slot 0 in the LSBs).
module enemy_fire_arbiter
    import enemy_pkg::*;
#(
    parameter  int N_REQ    = ENEMY_N_REQ,
    parameter  int N_SLOT   = 2,
    parameter  int COOLDOWN = ENEMY_COOLDOWN,
    parameter  int LIFETIME = ENEMY_BULLET_LIFETIME,
    localparam int OW       = owner_width(N_REQ)
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 play,
    input  logic                 flush,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_dir,
    input  logic [N_SLOT-1:0]    slot_done,
    output logic [N_REQ-1:0]     grant,
    output logic [N_SLOT-1:0]    slot_fire,
    output logic [N_SLOT-1:0]    slot_dir,
    output logic [N_SLOT-1:0]    slot_busy,
    output logic [N_SLOT*OW-1:0] slot_owner
);

    logic [7:0]        cooldown [N_REQ];
    logic [OW-1:0]     rr;
    logic [N_REQ-1:0]  eligible;
    logic [N_SLOT-1:0] slot_sel;
    logic              have_slot;
    logic              have_req;
    logic              do_grant;
    logic [OW-1:0]     grant_idx;
    logic [N_REQ-1:0]  grant_vec;
    logic [N_SLOT-1:0] launch;

    always_comb begin
        eligible  = '0;
        slot_sel  = '0;
        have_slot = 1'b0;
        have_req  = 1'b0;
        grant_idx = '0;
        grant_vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req[i] && (cooldown[i] == 8'd0);
        end
        // Target is decided from current slot state only, so a slot freed
        // at this edge is not reusable until the next one.
        for (int s = 0; s < N_SLOT; s++) begin
            if (!have_slot && !slot_busy[s]) begin
                slot_sel[s] = 1'b1;
                have_slot   = 1'b1;
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            if (!have_req && eligible[(int'(rr) + k) % N_REQ]) begin
                have_req  = 1'b1;
                grant_idx = OW'((int'(rr) + k) % N_REQ);
            end
        end
        do_grant             = have_slot && have_req && play && !flush;
        grant_vec[grant_idx] = do_grant;
        launch               = do_grant ? slot_sel : '0;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            grant <= '0;
            rr    <= '0;
            for (int i = 0; i < N_REQ; i++) cooldown[i] <= 8'd0;
        end else if (flush) begin
            grant <= '0;
            rr    <= '0;
            for (int i = 0; i < N_REQ; i++) cooldown[i] <= 8'd0;
        end else if (!play) begin
            grant <= '0;
        end else begin
            grant <= grant_vec;
            if (do_grant) rr <= OW'((int'(grant_idx) + 1) % N_REQ);
            // A freshly loaded cooldown does not also decrement this frame.
            for (int i = 0; i < N_REQ; i++) begin
                if (do_grant && grant_idx == OW'(i)) begin
                    cooldown[i] <= 8'(COOLDOWN);
                end else if (cooldown[i] != 8'd0) begin
                    cooldown[i] <= cooldown[i] - 8'd1;
                end
            end
        end
    end

    for (genvar s = 0; s < N_SLOT; s++) begin : g_slot
        enemy_fire_slot #(
            .LIFETIME (LIFETIME),
            .OW       (OW)
        ) u_slot (
            .frame_clk    (frame_clk),
            .Reset        (Reset),
            .play         (play),
            .flush        (flush),
            .launch       (launch[s]),
            .launch_owner (grant_idx),
            .launch_dir   (req_dir[grant_idx]),
            .slot_done    (slot_done[s]),
            .fire         (slot_fire[s]),
            .dir          (slot_dir[s]),
            .busy         (slot_busy[s]),
            .owner        (slot_owner[s*OW +: OW])
        );
    end

endmodule

// File: tb/tb_enemy_fire_arbiter.sv
// tb/tb_enemy_fire_arbiter.sv - self-checking bench for enemy_fire_arbiter
module tb_enemy_fire_arbiter;

    localparam int N_REQ    = 4;
    localparam int N_SLOT   = 2;
    localparam int COOLDOWN = 120;
    localparam int LIFETIME = 200;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic        play;
    logic        flush;
    logic [3:0]  req;
    logic [3:0]  req_dir;
    logic [1:0]  slot_done;
    logic [3:0]  grant;
    logic [1:0]  slot_fire;
    logic [1:0]  slot_dir;
    logic [1:0]  slot_busy;
    logic [3:0]  slot_owner;
    logic [13:0] act;

    int checks = 0;
    int errors = 0;

    // Reference model: a slot is described by its age in frames since launch
    // (-1 = free); cooldown by the play-frame number at which it may fire again.
    int         age [N_SLOT];
    int         next_ok [N_REQ];
    int         m_owner [N_SLOT];
    logic [1:0] m_dir;
    logic [3:0] m_grant;
    logic [1:0] m_fire;
    int         m_rr;
    int         ptime;

    enemy_fire_arbiter #(
        .N_REQ    (N_REQ),
        .N_SLOT   (N_SLOT),
        .COOLDOWN (COOLDOWN),
        .LIFETIME (LIFETIME)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .play       (play),
        .flush      (flush),
        .req        (req),
        .req_dir    (req_dir),
        .slot_done  (slot_done),
        .grant      (grant),
        .slot_fire  (slot_fire),
        .slot_dir   (slot_dir),
        .slot_busy  (slot_busy),
        .slot_owner (slot_owner)
    );

    always #5 frame_clk = ~frame_clk;

    assign act = {grant, slot_fire, slot_busy, slot_dir, slot_owner};

    function automatic logic [13:0] exp_vec();
        logic [1:0] busy;
        for (int s = 0; s < N_SLOT; s++) busy[s] = (age[s] >= 0);
        return {m_grant, m_fire, busy, m_dir, 2'(m_owner[1]), 2'(m_owner[0])};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < N_SLOT; s++) begin
            age[s]     = -1;
            m_owner[s] = 0;
        end
        for (int i = 0; i < N_REQ; i++) next_ok[i] = 0;
        m_dir   = '0;
        m_grant = '0;
        m_fire  = '0;
        m_rr    = 0;
        ptime   = 0;
    endtask

    task automatic model_edge();
        int tgt;
        int g;
        m_grant = '0;
        m_fire  = '0;
        if (flush) begin
            for (int s = 0; s < N_SLOT; s++) age[s] = -1;
            for (int i = 0; i < N_REQ; i++) next_ok[i] = 0;
            m_rr = 0;
        end else if (play) begin
            tgt = -1;
            for (int s = N_SLOT - 1; s >= 0; s--) if (age[s] < 0) tgt = s;
            g = -1;
            if (tgt >= 0) begin
                for (int k = 0; k < N_REQ; k++) begin
                    int i = (m_rr + k) % N_REQ;
                    if (g < 0 && req[i] && ptime >= next_ok[i]) g = i;
                end
            end
            for (int s = 0; s < N_SLOT; s++) begin
                if (age[s] >= 0) begin
                    if (age[s] >= 1 && (slot_done[s] || age[s] == LIFETIME)) age[s] = -1;
                    else age[s]++;
                end
            end
            if (g >= 0) begin
                age[tgt]     = 0;
                m_owner[tgt] = g;
                m_dir[tgt]   = req_dir[g];
                next_ok[g]   = ptime + COOLDOWN + 1;
                m_rr         = (g + 1) % N_REQ;
                m_grant[g]   = 1'b1;
                m_fire[tgt]  = 1'b1;
            end
            ptime++;
        end
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
        model_edge();
    endtask

    task automatic do_reset();
        Reset     = 1'b1;
        play      = 1'b1;
        flush     = 1'b0;
        req       = '0;
        req_dir   = '0;
        slot_done = '0;
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset     = 1'b1;
        play      = 1'b1;
        flush     = 1'b0;
        req       = 4'b1111;
        req_dir   = 4'b0101;
        slot_done = '0;
        model_reset();
        #1;
        checks++;
        if (act !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", act, 14'd0);
        end
        @(negedge frame_clk);
        Reset = 1'b0;
        step();
        checks++;
        if (grant !== 4'b0001 || slot_fire !== 2'b01 || slot_owner[1:0] !== 2'd0) begin
            errors++;
            $display("FAIL first_grant: got grant=%b fire=%b owner0=%0d expected 0001 01 0",
                     grant, slot_fire, slot_owner[1:0]);
        end
        step();
        checks++;
        if (grant !== 4'b0010 || slot_fire !== 2'b10 || slot_owner[3:2] !== 2'd1) begin
            errors++;
            $display("FAIL second_grant: got grant=%b fire=%b owner1=%0d expected 0010 10 1",
                     grant, slot_fire, slot_owner[3:2]);
        end
        step();
        checks++;
        if (act !== exp_vec() || grant !== 4'b0000) begin
            errors++;
            $display("FAIL no_free_slot: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_cooldown_period();
        int launch_at [N_SLOT];
        int gframes [$];
        do_reset();
        req     = 4'b0100;
        req_dir = 4'b0100;
        for (int s = 0; s < N_SLOT; s++) launch_at[s] = -100;
        for (int f = 0; f < 260; f++) begin
            for (int s = 0; s < N_SLOT; s++) slot_done[s] = (f == launch_at[s] + 5);
            step();
            for (int s = 0; s < N_SLOT; s++) if (m_fire[s]) launch_at[s] = f;
            if (grant[2]) gframes.push_back(f);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL cooldown_frame_%0d: got %h expected %h", f, act, exp_vec());
            end
        end
        checks++;
        if (gframes.size() != 3 || gframes[0] != 0 || gframes[1] != 121 || gframes[2] != 242) begin
            errors++;
            $display("FAIL cooldown_period: got %0d grants (%p) expected frames 0 121 242",
                     gframes.size(), gframes);
        end
        slot_done = '0;
    endtask

    task automatic test_slot_reuse();
        do_reset();
        req = 4'b0011;
        step();
        step();
        req = 4'b0000;
        repeat (3) step();
        req       = 4'b1000;
        req_dir   = 4'b1000;
        slot_done = 2'b01;
        step();
        checks++;
        if (act !== exp_vec() || grant !== 4'b0000 || slot_busy !== 2'b10) begin
            errors++;
            $display("FAIL reuse_edge_k: got grant=%b busy=%b expected 0000 10", grant, slot_busy);
        end
        slot_done = 2'b00;
        step();
        checks++;
        if (act !== exp_vec() || grant !== 4'b1000 || slot_fire !== 2'b01) begin
            errors++;
            $display("FAIL reuse_edge_k1: got grant=%b fire=%b expected 1000 01", grant, slot_fire);
        end
    endtask

    task automatic test_lifetime();
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0000;
        for (int n = 1; n <= LIFETIME + 1; n++) begin
            step();
            checks++;
            if (slot_busy[0] !== (n < LIFETIME + 1) || act !== exp_vec()) begin
                errors++;
                $display("FAIL lifetime_edge_%0d: got busy0=%b act=%h expected busy0=%b act=%h",
                         n, slot_busy[0], act, (n < LIFETIME + 1), exp_vec());
            end
        end
    endtask

    task automatic test_pause();
        logic [13:0] held;
        do_reset();
        req     = 4'b1111;
        req_dir = 4'b0110;
        step();
        step();
        req = 4'b0000;
        repeat (10) step();
        held = exp_vec();
        play = 1'b0;
        for (int f = 0; f < 50; f++) begin
            req       = 4'($urandom);
            req_dir   = 4'($urandom);
            slot_done = 2'($urandom);
            step();
            checks++;
            if (act !== exp_vec() || act[13:10] !== 4'd0 || act[9:0] !== held[9:0]) begin
                errors++;
                $display("FAIL pause_frame_%0d: got %h expected %h", f, act, held);
            end
        end
        play = 1'b1;
        for (int f = 0; f < 150; f++) begin
            req       = 4'($urandom);
            req_dir   = 4'($urandom);
            slot_done = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            step();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL resume_frame_%0d: got %h expected %h", f, act, exp_vec());
            end
        end
        slot_done = '0;
    endtask

    task automatic test_flush();
        do_reset();
        req = 4'b0011;
        step();
        step();
        flush = 1'b1;
        step();
        checks++;
        if (act !== exp_vec() || slot_busy !== 2'b00 || grant !== 4'b0000) begin
            errors++;
            $display("FAIL flush_clear: got busy=%b grant=%b expected 00 0000", slot_busy, grant);
        end
        flush = 1'b0;
        req   = 4'b1111;
        step();
        checks++;
        if (act !== exp_vec() || grant !== 4'b0001) begin
            errors++;
            $display("FAIL flush_regrant: got grant=%b expected 0001", grant);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req     = 4'b0001;
        req_dir = 4'b0001;
        step();
        req = 4'b0000;
        repeat (3) step();
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (act !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", act, 14'd0);
        end
        model_reset();
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 2000; f++) begin
            play      = ($urandom_range(0, 9) != 0);
            flush     = ($urandom_range(0, 99) == 0);
            req       = 4'($urandom);
            req_dir   = 4'($urandom);
            slot_done = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            step();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL random_frame_%0d: got %h expected %h", f, act, exp_vec());
            end
        end
        play      = 1'b1;
        flush     = 1'b0;
        slot_done = '0;
    endtask

    initial begin
        test_reset();
        test_cooldown_period();
        test_slot_reuse();
        test_lifetime();
        test_pause();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
